// File: rtl/fma16_normround.sv
// Normalize-and-round stage of the fp16 FMA: shifts the sum mantissa one bit per
// cycle into normal/subnormal position, then rounds to binary16 with flags.
module fma16_normround #(
    parameter int VEC_SIZE = 45,
    parameter int END_BITS = 11
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                ss,
    input  logic [6:0]          se,
    input  logic [VEC_SIZE-1:0] sm,
    input  logic [1:0]          roundmode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         result,
    output logic [3:0]          flags
);
    localparam int POINT = END_BITS + 20;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;

    state_t                state_reg, state_next;
    logic [VEC_SIZE-1:0]   m_reg, m_next;
    logic signed [8:0]     e_reg, e_next;
    logic                  st_reg, st_next;
    logic                  sign_reg, sign_next;
    logic [1:0]            rm_reg, rm_next;
    logic [15:0]           result_reg, result_next;
    logic [3:0]            flags_reg, flags_next;

    // Rounding datapath, only consumed in ROUND
    logic [9:0]            frac;
    logic                  guard, sticky, inexact, inc;
    logic [11:0]           sum12;
    logic                  carry, hidden, tiny, ovf;
    logic signed [8:0]     e_fin;
    logic [15:0]           round_result;
    logic [3:0]            round_flags;

    always_comb begin
        frac    = m_reg[POINT-1:POINT-10];
        guard   = m_reg[POINT-11];
        sticky  = st_reg | (|m_reg[POINT-12:0]);
        inexact = guard | sticky;
        case (rm_reg)
            2'b00:   inc = 1'b0;
            2'b01:   inc = guard & (sticky | frac[0]);
            2'b10:   inc = inexact & sign_reg;
            default: inc = inexact & ~sign_reg;
        endcase
        sum12  = {1'b0, m_reg[POINT], frac} + {11'b0, inc};
        carry  = sum12[11];
        hidden = carry | sum12[10];
        e_fin  = e_reg + {8'b0, carry};
        tiny   = ~m_reg[POINT];
        ovf    = (e_fin >= 9'sd31);

        if (m_reg == '0) begin
            round_result = (rm_reg == 2'b10) ? 16'h8000 : 16'h0000;
            round_flags  = 4'b0000;
        end else if (ovf) begin
            // Directed modes that round away from the overflow side saturate at max finite
            if (rm_reg == 2'b01 || (rm_reg == 2'b11 && !sign_reg) || (rm_reg == 2'b10 && sign_reg))
                round_result = {sign_reg, 15'h7C00};
            else
                round_result = {sign_reg, 15'h7BFF};
            round_flags = 4'b0101;
        end else begin
            round_result = {sign_reg, (hidden ? e_fin[4:0] : 5'd0), sum12[9:0]};
            round_flags  = {2'b00, tiny & inexact, inexact};
        end
    end

    always_comb begin
        state_next  = state_reg;
        m_next      = m_reg;
        e_next      = e_reg;
        st_next     = st_reg;
        sign_next   = sign_reg;
        rm_next     = rm_reg;
        result_next = result_reg;
        flags_next  = flags_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = NORM;
                    m_next     = sm;
                    e_next     = {{2{se[6]}}, se};
                    st_next    = 1'b0;
                    sign_next  = ss;
                    rm_next    = roundmode;
                end
            end
            NORM: begin
                if (m_reg == '0) begin
                    state_next = ROUND;
                end else if ((|m_reg[VEC_SIZE-1:POINT+1]) || (e_reg < 9'sd1)) begin
                    m_next  = {1'b0, m_reg[VEC_SIZE-1:1]};
                    e_next  = e_reg + 9'sd1;
                    st_next = st_reg | m_reg[0];
                end else if (!m_reg[POINT] && (e_reg > 9'sd1)) begin
                    m_next = {m_reg[VEC_SIZE-2:0], 1'b0};
                    e_next = e_reg - 9'sd1;
                end else begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next  = HOLD;
                result_next = round_result;
                flags_next  = round_flags;
            end
            HOLD: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            m_reg      <= '0;
            e_reg      <= '0;
            st_reg     <= 1'b0;
            sign_reg   <= 1'b0;
            rm_reg     <= 2'b00;
            result_reg <= 16'h0000;
            flags_reg  <= 4'b0000;
        end else begin
            state_reg  <= state_next;
            m_reg      <= m_next;
            e_reg      <= e_next;
            st_reg     <= st_next;
            sign_reg   <= sign_next;
            rm_reg     <= rm_next;
            result_reg <= result_next;
            flags_reg  <= flags_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == HOLD);
    assign result    = result_reg;
    assign flags     = flags_reg;
endmodule

// File: tb/tb_fma16_normround.sv
// Randomized + directed scoreboard bench for fma16_normround against a closed-form
// normalize/round reference model.
module tb_fma16_normround;
    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        ss;
    logic [6:0]  se;
    logic [44:0] sm;
    logic [1:0]  roundmode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    fma16_normround #(.VEC_SIZE(45), .END_BITS(11)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ss(ss), .se(se), .sm(sm), .roundmode(roundmode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_txn    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: the final shift is d = max(msb-31, 1-se) (positive = right),
    // then binary16 rounding of the 11-bit significand at bit 31.
    task automatic model(input logic [44:0] sm_i, input int e0, input bit s, input bit [1:0] rm,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
        int p, d, e, q;
        logic [127:0] wide, kept;
        bit sticky, g, st, x, inc, tiny;
        r = 16'h0; f = 4'h0;
        if (sm_i == '0) begin
            r = (rm == 2'b10) ? 16'h8000 : 16'h0000;
            lat = 2;
            return;
        end
        p = 0;
        for (int i = 0; i < 45; i++) if (sm_i[i]) p = i;
        d = (p - 31 > 1 - e0) ? p - 31 : 1 - e0;
        if (d > p) begin
            r = (rm == 2'b10) ? 16'h8000 : 16'h0000;
            lat = p + 1 + 2;
            return;
        end
        wide = {83'b0, sm_i};
        if (d >= 0) begin
            kept   = wide >> d;
            sticky = ((kept << d) != wide);
        end else begin
            kept   = wide << (-d);
            sticky = 1'b0;
        end
        lat = ((d < 0) ? -d : d) + 2;
        e  = e0 + d;
        q  = int'(kept[31:21]);
        g  = kept[20];
        st = sticky || (kept[19:0] != 0);
        x  = g | st;
        case (rm)
            2'b00:   inc = 0;
            2'b01:   inc = g & (st | kept[21]);
            2'b10:   inc = x & s;
            default: inc = x & ~s;
        endcase
        tiny = (q < 1024);
        q = q + int'(inc);
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        if (e >= 31) begin
            if (rm == 2'b01 || (rm == 2'b11 && !s) || (rm == 2'b10 && s)) r = {s, 15'h7C00};
            else r = {s, 15'h7BFF};
            f = 4'b0101;
        end else begin
            r = {s, (q >= 1024) ? 5'(e) : 5'd0, 10'(q)};
            f = {2'b00, tiny & x, x};
        end
    endtask

    task automatic issue(input logic [44:0] sm_i, input int e0, input bit s, input bit [1:0] rm,
                         input bit push);
        int t;
        exp_t ex;
        int lat;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", t);
        end
        sm = sm_i; se = e0[6:0]; ss = s; roundmode = rm; in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            model(sm_i, e0, s, rm, ex.res, ex.flg, lat);
            ex.due = cyc + lat;
            sb.push_back(ex);
        end
        in_valid = 1'b0;
        sm = {$urandom, $urandom};
        se = 7'($urandom);
        ss = 1'($urandom);
        roundmode = 2'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending", sb.size());
        end
    endtask

    // Consumer: first result is held off for 5 cycles, later ones for a random 0..3
    int hold_left;
    initial begin
        out_ready = 1'b0;
        hold_left = 5;
        forever begin
            @(negedge clk);
            if (!reset_n || !out_valid) begin
                out_ready = 1'b0;
            end else if (hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = 1'b1;
                hold_left = $urandom_range(0, 3);
            end
        end
    end

    // Monitor
    initial begin
        bit   prev_ov;
        exp_t cur;
        prev_ov = 1'b0;
        cur.res = '0; cur.flg = '0; cur.due = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: result 0x%04h with empty scoreboard", result);
                    end else begin
                        cur = sb.pop_front();
                        n_txn++;
                        $display("txn %0d: result=0x%04h flags=%04b expected 0x%04h/%04b at cycle %0d (due %0d)",
                                 n_txn, result, flags, cur.res, cur.flg, cyc, cur.due);
                        chk("result", 32'(result), 32'(cur.res));
                        chk("flags", 32'(flags), 32'(cur.flg));
                        chk("latency", 32'(cyc), 32'(cur.due));
                    end
                end else if (out_valid) begin
                    chk("hold_result", 32'(result), 32'(cur.res));
                    chk("hold_flags", 32'(flags), 32'(cur.flg));
                end
                prev_ov = out_valid;
            end
        end
    end

    typedef struct {
        logic [44:0] m;
        int          e;
        bit          s;
        bit [1:0]    rm;
    } vec_t;

    initial begin
        vec_t dir[$];
        logic [63:0] rnd;
        int t;
        reset_n = 1'b0; in_valid = 1'b0; ss = 1'b0; se = '0; sm = '0; roundmode = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);

        dir.push_back('{45'd1 << 31, 15, 0, 2'b01});
        dir.push_back('{45'd1 << 32, 15, 0, 2'b01});
        dir.push_back('{45'd1 << 21, 25, 0, 2'b01});
        dir.push_back('{(45'd1 << 31) | (45'd1 << 20), 15, 0, 2'b01});
        dir.push_back('{(45'd1 << 31) | (45'd1 << 20), 15, 0, 2'b11});
        dir.push_back('{(45'd1 << 31) | (45'd1 << 20), 15, 0, 2'b00});
        dir.push_back('{(45'd1 << 31) | (45'd1 << 20), 15, 1, 2'b10});
        dir.push_back('{45'd1 << 31, 31, 0, 2'b01});
        dir.push_back('{45'd1 << 31, 31, 0, 2'b00});
        dir.push_back('{45'd1 << 31, -9, 0, 2'b01});
        dir.push_back('{(45'd1 << 31) | 45'd1, -9, 0, 2'b01});
        dir.push_back('{45'd0, 3, 0, 2'b10});
        dir.push_back('{{45{1'b1}}, -64, 1, 2'b11});
        dir.push_back('{45'h7FF << 21, 30, 0, 2'b01});
        foreach (dir[i]) issue(dir[i].m, dir[i].e, dir[i].s, dir[i].rm, 1'b1);

        for (int i = 0; i < 150; i++) begin
            rnd = {$urandom, $urandom};
            issue(45'(rnd) >> $urandom_range(0, 45), int'($urandom_range(0, 127)) - 64,
                  1'($urandom), 2'($urandom), 1'b1);
        end
        issue(45'd1 << 31, 15, 0, 2'b01, 1'b1);
        drain();

        // Reset in the middle of a 13-shift normalization drops the operation
        issue(45'd1 << 44, 10, 0, 2'b01, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_result", 32'(result), 32'd0);
        chk("midreset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postreset_in_ready", 32'(in_ready), 32'd1);
        t = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) t++;
        end
        chk("dropped_op_no_output", 32'(t), 32'd0);

        issue((45'd1 << 31) | (45'd1 << 20), 15, 0, 2'b11, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fma16_normround.md
# fma16_normround

Normalize-and-round stage of the fp16 FMA datapath. Sits directly downstream of the sum stage and consumes its sign, wide exponent and unnormalized sum mantissa. Iteratively shifts the mantissa one bit per cycle until it is normalized or subnormal. Rounds to binary16 under one of four rounding modes and returns the packed result with flags over a valid/ready handshake.

## Interface
- `VEC_SIZE`, 45: sum mantissa width.
- `END_BITS`, 11: low guard bits below the product field. Binary point `POINT = END_BITS+20`: the bit of `sm` worth 1.0.
- `clk` in 1: clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `ss`/`se`/`sm`/`roundmode` are valid.
- `in_ready` out 1: block can accept an operation.
- `ss` in 1: sum sign.
- `se` in 7: two's-complement biased exponent. Value = (-1)^ss × sm × 2^(se−15−POINT).
- `sm` in VEC_SIZE: unnormalized unsigned sum magnitude.
- `roundmode` in 2: 00 RZ, 01 RNE, 10 RM (toward −inf), 11 RP (toward +inf).
- `out_valid` out 1: `result`/`flags` are valid.
- `out_ready` in 1: consumer takes the result.
- `result` out 16: packed binary16.
- `flags` out 4: {invalid, overflow, underflow, inexact}. `invalid` is always 0 here.

## Operation
- FSM states and transitions:
  - IDLE → NORM on `in_valid`.
  - NORM → NORM while shifting.
  - NORM → ROUND when the stop condition holds.
  - ROUND → HOLD.
  - HOLD → IDLE on `out_ready`.
- `in_ready` = (state==IDLE). Only one operation is in flight.
- Accept: latch `sm` into mantissa register `m` (VEC_SIZE bits). Sign-extend `se` into 9-bit signed `e`. Clear sticky `st`, latch `ss` and `roundmode`.
- NORM, evaluated in this priority order each cycle:
  1. `m`==0 → stop.
  2. Any bit of `m` above POINT set → shift right 1, `e`+1, `st |= m[0]`.
  3. `e`<1 → same right shift (gradual underflow).
  4. `m[POINT]`==0 and `e`>1 → shift left 1, `e`−1.
  5. Otherwise stop.
- ROUND:
  - Fraction `f = m[POINT-1:POINT-10]`.
  - Guard `g = m[POINT-11]`.
  - Sticky `s = st | OR(m[POINT-12:0])`.
  - Inexact `x = g|s`.
  - Increment rules:
    - RNE: `g&(s|f[0])`.
    - RZ: 0.
    - RP: `x & ~sign`.
    - RM: `x & sign`.
  - Form `{m[POINT],f}+inc`. On carry out of 11 bits: fraction 0, `e`+1.
  - Subnormal promoting to 2^−14 needs no special case: `m[POINT]`=1 yields exponent field 1.
- Exponent field: `e` if `m[POINT]`=1 after rounding, else 0.
- Overflow: final `e`≥31.
  - Result is inf (0x7C00 | sign<<15) for RNE, RP with sign=0, and RM with sign=1.
  - Result is max finite 0x7BFF | sign<<15 for all other cases.
  - Flags overflow=1, inexact=1.
- Zero: `m`==0 gives result 0x0000, or 0x8000 if roundmode==RM. Flags 0.
- Underflow flag = tiny (exponent field 0 before rounding carry) AND `x`. Inexact flag = `x` or overflow.

## Timing
- Accept edge E0. NORM lasts k+1 cycles for k shifts. ROUND lasts 1 cycle. `out_valid` rises after edge E0+k+2.
- Minimum latency is 2, when no shift is needed. Maximum latency is bounded by VEC_SIZE+40.
- HOLD: `result`/`flags` stay stable until the `out_ready` edge. `out_valid` falls on the same edge. `in_ready` rises on the following cycle; there is no same-cycle re-accept.
- `in_valid` while not IDLE is ignored. Inputs are sampled only at accept.
- Reset, at any time including mid-NORM/HOLD: state IDLE, `in_ready`=1 once reset is released, `out_valid`=0, `result`=0x0000, `flags`=0. The in-flight operation is dropped.
- `result` and `flags` are registered outputs, loaded only on ROUND→HOLD.

## Test plan
- sm=1<<31, se=15, RNE → 0x3C00, flags 0, `out_valid` 2 cycles after accept.
- sm=1<<32, se=15 → 0x4000 after 1 right shift, latency 3. sm=1<<21, se=25 → 0x3C00, 10 left shifts, latency 12.
- sm=(1<<31)|(1<<20), se=15, ss=0:
  - RNE → 0x3C00, inexact.
  - RP → 0x3C01.
  - RZ → 0x3C00.
  - With ss=1 and RM → 0xBC01.
- sm=1<<31, se=31:
  - RNE → 0x7C00, flags 0101.
  - RZ → 0x7BFF, flags 0101.
- sm=1<<31, se=−9 → 0x0001, flags 0. sm=(1<<31)|1, se=−9, RNE → 0x0001, flags 0011.
- sm=0, RM → 0x8000.
- Hold `out_ready`=0 for 5 cycles: result stays stable.
- Assert `reset_n`=0 mid-NORM: outputs return to 0 and `in_ready`=1 after release.
